// File: rtl/niosii_debug_cmd_sequencer.sv
// Command/response front-end that sequences Nios II OCI debug strobes (halt, resume,
// monitor reads and writes) in the system clock domain, with timeout and error reporting.
module niosii_debug_cmd_sequencer #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              debugack,
  input  logic              monitor_ready,
  input  logic              monitor_error,
  input  logic [31:0]       MonDReg,
  output logic [37:0]       jdo,
  output logic              take_action_ocimem_a,
  output logic              take_action_ocimem_b,
  output logic              take_no_action_ocimem_a,
  output logic              take_action_break_a,
  output logic              take_action_break_b
);

  localparam int unsigned JDO_W  = 38;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_HALT   = 3'd3;
  localparam logic [2:0] OP_RESUME = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_HWAIT, S_ADDR, S_WDATA, S_RDREQ, S_MWAIT, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic                timeout;
  logic                rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                oa_d, ob_d, na_d, ba_d, bb_d;
  logic [JDO_W-1:0]    jdo_d;

  function automatic logic [JDO_W-1:0] jdo_mem_a(input logic wr, input logic [ADDR_W-1:0] a);
    logic [JDO_W-1:0] j;
    j = '0;
    j[35] = wr;
    j[ADDR_W-1:0] = a;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] jdo_mem_b(input logic [DATA_W-1:0] d);
    logic [JDO_W-1:0] j;
    j = '0;
    j[37:36] = 2'b01;
    j[DATA_W-1:0] = d;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] jdo_rd_req(input logic [ADDR_W-1:0] a);
    logic [JDO_W-1:0] j;
    j = '0;
    j[37:36] = 2'b10;
    j[ADDR_W-1:0] = a;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] jdo_break(input logic resume);
    logic [JDO_W-1:0] j;
    j = '0;
    j[37:36] = 2'b11;
    j[0] = ~resume;
    j[1] = resume;
    return j;
  endfunction

  assign cmd_ready = (state_q == S_IDLE);
  assign timeout   = (timer_q == TIMER_MAX);
  assign timer_inc = timeout ? timer_q : timer_q + TW'(1);

  // Strobes are decided on the transition into the state that owns them, so each
  // pulse is registered and lasts exactly the first cycle of that state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timer_d     = '0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    oa_d        = 1'b0;
    ob_d        = 1'b0;
    na_d        = 1'b0;
    ba_d        = 1'b0;
    bb_d        = 1'b0;
    jdo_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (cmd_op)
            OP_WRITE, OP_READ: begin
              if (debugack) begin
                state_d = S_ADDR;
                oa_d    = 1'b1;
                jdo_d   = jdo_mem_a(cmd_op == OP_WRITE, cmd_addr);
              end else begin
                state_d = S_HALT;
                ba_d    = 1'b1;
                jdo_d   = jdo_break(1'b0);
              end
            end
            OP_HALT: begin
              state_d = S_HALT;
              ba_d    = 1'b1;
              jdo_d   = jdo_break(1'b0);
            end
            OP_RESUME: begin
              state_d     = S_RESP;
              bb_d        = 1'b1;
              jdo_d       = jdo_break(1'b1);
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_data_d  = '0;
            end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      S_HALT: begin
        state_d = S_HWAIT;
      end
      S_HWAIT: begin
        if (debugack) begin
          if (op_q == OP_WRITE || op_q == OP_READ) begin
            state_d = S_ADDR;
            oa_d    = 1'b1;
            jdo_d   = jdo_mem_a(op_q == OP_WRITE, addr_q);
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end
        end else if (timeout) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_ADDR: begin
        if (op_q == OP_WRITE) begin
          state_d = S_WDATA;
          ob_d    = 1'b1;
          jdo_d   = jdo_mem_b(data_q);
        end else begin
          state_d = S_RDREQ;
          na_d    = 1'b1;
          jdo_d   = jdo_rd_req(addr_q);
        end
      end
      S_WDATA, S_RDREQ: begin
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (monitor_ready) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = monitor_error;
          rsp_data_d  = (op_q == OP_READ && !monitor_error) ? MonDReg : '0;
        end else if (timeout) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q                 <= S_IDLE;
      op_q                    <= '0;
      addr_q                  <= '0;
      data_q                  <= '0;
      timer_q                 <= '0;
      rsp_valid               <= 1'b0;
      rsp_data                <= '0;
      rsp_err                 <= 1'b0;
      take_action_ocimem_a    <= 1'b0;
      take_action_ocimem_b    <= 1'b0;
      take_no_action_ocimem_a <= 1'b0;
      take_action_break_a     <= 1'b0;
      take_action_break_b     <= 1'b0;
      jdo                     <= '0;
    end else begin
      state_q                 <= state_d;
      op_q                    <= op_d;
      addr_q                  <= addr_d;
      data_q                  <= data_d;
      timer_q                 <= timer_d;
      rsp_valid               <= rsp_valid_d;
      rsp_data                <= rsp_data_d;
      rsp_err                 <= rsp_err_d;
      take_action_ocimem_a    <= oa_d;
      take_action_ocimem_b    <= ob_d;
      take_no_action_ocimem_a <= na_d;
      take_action_break_a     <= ba_d;
      take_action_break_b     <= bb_d;
      jdo                     <= jdo_d;
    end
  end

endmodule

// File: tb/tb_niosii_debug_cmd_sequencer.sv
// Directed bench for niosii_debug_cmd_sequencer: strobe order, jdo words, latency,
// timeout, error responses, back-pressure and reset behaviour.
module tb_niosii_debug_cmd_sequencer;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TO     = 8;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_OA   = 5'b00001;
  localparam logic [4:0] S_OB   = 5'b00010;
  localparam logic [4:0] S_NA   = 5'b00100;
  localparam logic [4:0] S_BA   = 5'b01000;
  localparam logic [4:0] S_BB   = 5'b10000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              debugack;
  logic              monitor_ready;
  logic              monitor_error;
  logic [31:0]       MonDReg;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic              take_action_break_a;
  logic              take_action_break_b;
  logic [4:0]        strb;

  int checks = 0;
  int errors = 0;

  niosii_debug_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_op                  (cmd_op),
    .cmd_addr                (cmd_addr),
    .cmd_data                (cmd_data),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_data                (rsp_data),
    .rsp_err                 (rsp_err),
    .debugack                (debugack),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .MonDReg                 (MonDReg),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_break_a     (take_action_break_a),
    .take_action_break_b     (take_action_break_b)
  );

  always #5 clk = ~clk;

  assign strb = {take_action_break_b, take_action_break_a, take_no_action_ocimem_a,
                 take_action_ocimem_b, take_action_ocimem_a};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; at most one strobe may ever be high.
  task automatic tick();
    @(negedge clk);
    chk("onehot_strobe", 64'($countones(strb) <= 1), 64'd1);
  endtask

  task automatic strobe_is(input string tag, input logic [4:0] s, input logic [37:0] j);
    chk({tag, "_strb"}, 64'(strb), 64'(s));
    chk({tag, "_jdo"}, 64'(jdo), 64'(j));
  endtask

  task automatic rsp_is(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, "_err"}, 64'(rsp_err), 64'(e));
    chk({tag, "_data"}, 64'(rsp_data), 64'(d));
  endtask

  // Presents one command; returns on the falling edge after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_hs_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    cmd_valid     = 1'b1;
    cmd_op        = 3'd1;
    cmd_addr      = 9'h1A5;
    cmd_data      = 32'hDEADBEEF;
    rsp_ready     = 1'b0;
    debugack      = 1'b1;
    monitor_ready = 1'b0;
    monitor_error = 1'b0;
    MonDReg       = 32'h0;

    // Reset with a command already pending
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    strobe_is("rst", S_NONE, 38'h0);
    rsp_is("rst", 1'b0, 1'b0, 32'h0);
    reset_n = 1'b1;

    // MEM_WRITE, debugack already high, monitor_ready two cycles after ocimem_b
    tick();
    cmd_valid = 1'b0;
    chk("wr_busy", 64'(cmd_ready), 64'd0);
    strobe_is("wr_a", S_OA, 38'h08_000001A5);
    tick();
    strobe_is("wr_b", S_OB, 38'h10_DEADBEEF);
    tick();
    strobe_is("wr_mw0", S_NONE, 38'h0);
    chk("wr_mw0_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("wr_mw1_valid", 64'(rsp_valid), 64'd0);
    monitor_ready = 1'b1;
    tick();
    monitor_ready = 1'b0;
    rsp_is("wr_rsp", 1'b1, 1'b0, 32'h0);
    handshake("wr");

    // MEM_READ requiring a halt; debugack rises three cycles after break_a
    debugack = 1'b0;
    send(3'd2, 9'h010, 32'h0);
    strobe_is("rd_halt", S_BA, 38'h30_00000001);
    tick();
    strobe_is("rd_hw0", S_NONE, 38'h0);
    tick();
    strobe_is("rd_hw1", S_NONE, 38'h0);
    tick();
    debugack = 1'b1;
    tick();
    strobe_is("rd_a", S_OA, 38'h00_00000010);
    tick();
    strobe_is("rd_req", S_NA, 38'h20_00000010);
    tick();
    MonDReg       = 32'h12345678;
    monitor_ready = 1'b1;
    tick();
    monitor_ready = 1'b0;
    MonDReg       = 32'h0;
    rsp_is("rd_rsp", 1'b1, 1'b0, 32'h12345678);
    handshake("rd");

    // MEM_READ with the monitor silent: response exactly TO cycles after MWAIT entry
    MonDReg = 32'hA5A5A5A5;
    send(3'd2, 9'h055, 32'h0);
    strobe_is("to_a", S_OA, 38'h00_00000055);
    tick();
    strobe_is("to_req", S_NA, 38'h20_00000055);
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk("to_wait_valid", 64'(rsp_valid), 64'd0);
    end
    tick();
    rsp_is("to_rsp", 1'b1, 1'b1, 32'h0);
    handshake("to");

    // Read with monitor_error, then back-pressure while commands are offered
    MonDReg = 32'hFFFFFFFF;
    send(3'd2, 9'h1FF, 32'h0);
    strobe_is("er_a", S_OA, 38'h00_000001FF);
    tick();
    strobe_is("er_req", S_NA, 38'h20_000001FF);
    tick();
    monitor_ready = 1'b1;
    monitor_error = 1'b1;
    tick();
    monitor_ready = 1'b0;
    monitor_error = 1'b0;
    rsp_is("er_rsp", 1'b1, 1'b1, 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      rsp_is("bp", 1'b1, 1'b1, 32'h0);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      strobe_is("bp", S_NONE, 38'h0);
    end
    cmd_valid = 1'b0;
    handshake("er");
    tick();
    strobe_is("bp_ignored", S_NONE, 38'h0);
    chk("bp_ignored_valid", 64'(rsp_valid), 64'd0);

    // Invalid opcode
    send(3'd7, 9'h0, 32'h0);
    strobe_is("inv", S_NONE, 38'h0);
    rsp_is("inv_rsp", 1'b1, 1'b1, 32'h0);
    handshake("inv");

    // RESUME: single break_b pulse alongside the response
    send(3'd4, 9'h0, 32'h0);
    strobe_is("res", S_BB, 38'h30_00000002);
    rsp_is("res_rsp", 1'b1, 1'b0, 32'h0);
    tick();
    strobe_is("res_after", S_NONE, 38'h0);
    handshake("res");

    // HALT with debugack arriving one cycle into HWAIT
    debugack = 1'b0;
    send(3'd3, 9'h0, 32'h0);
    strobe_is("hlt", S_BA, 38'h30_00000001);
    tick();
    debugack = 1'b1;
    tick();
    strobe_is("hlt_rsp", S_NONE, 38'h0);
    rsp_is("hlt_rsp", 1'b1, 1'b0, 32'h0);
    handshake("hlt");

    // Reset in the middle of a write drops the strobe and yields no response
    send(3'd1, 9'h003, 32'h1);
    strobe_is("mid", S_OA, 38'h08_00000003);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strb", 64'(strb), 64'(S_NONE));
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_after_valid", 64'(rsp_valid), 64'd0);
    strobe_is("mid_after", S_NONE, 38'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
